// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two valid/ready requesters.
// One operation in flight at a time: IDLE accepts, EXEC captures the ALU output, RESP holds it until consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic grant_d;
  logic accept_d;
  logic rsp_ready_d;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    grant_d = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_grant_q;
    end
  end

  assign accept_d    = (state_q == IDLE) && !reset && (grant_d ? req1_valid : req0_valid);
  assign req0_ready  = accept_d && !grant_d;
  assign req1_ready  = accept_d && grant_d;
  assign rsp_ready_d = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 4'b0000;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            a_q          <= grant_d ? req1_a  : req0_a;
            b_q          <= grant_d ? req1_b  : req0_b;
            op_q         <= grant_d ? req1_op : req0_op;
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          zero_q   <= alu_zero;
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_ready_d) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;

  // Data outputs always carry the registers; only the valid qualifies them.
  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) && owner_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to its ALU-side ports.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference ALU: add/sub/and/or, anything else yields 0.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy0"}, {31'd0, req0_ready}, 32'd0);
    chk({tag, "_rdy1"}, {31'd0, req1_ready}, 32'd0);
    chk({tag, "_vld0"}, {31'd0, rsp0_valid}, 32'd0);
    chk({tag, "_vld1"}, {31'd0, rsp1_valid}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
    chk({tag, "_res"}, rsp0_result, 32'd0);
    chk({tag, "_zero"}, {31'd0, rsp0_zero}, 32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk_reset_state("rst");

    // Single req0: 5 + 7
    reset = 1'b0;
    set0(1'b1, 32'd5, 32'd7, 4'b0010);
    #1;
    chk("t1_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("t1_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    set0(1'b0, 32'd0, 32'd0, 4'b0000);
    #1;
    chk("t1_exec_alu_a", alu_a, 32'd5);
    chk("t1_exec_alu_b", alu_b, 32'd7);
    chk("t1_exec_ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("t1_exec_vld0", {31'd0, rsp0_valid}, 32'd0);
    tick();
    chk("t1_vld0", {31'd0, rsp0_valid}, 32'd1);
    chk("t1_res", rsp0_result, 32'd12);
    chk("t1_zero", {31'd0, rsp0_zero}, 32'd0);
    chk("t1_vld1", {31'd0, rsp1_valid}, 32'd0);
    rsp0_ready = 1'b1;
    tick();
    chk("t1_idle_vld0", {31'd0, rsp0_valid}, 32'd0);

    // Contention, responses always accepted; reset first so req0 wins
    reset = 1'b1; tick(); reset = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set0(1'b1, 32'd9, 32'd9, 4'b0110);
    set1(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 4'b0001);
    #1;
    chk("c_g0_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("c_g0_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("c_exec_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("c_exec_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("c_g0_vld0", {31'd0, rsp0_valid}, 32'd1);
    chk("c_g0_vld1", {31'd0, rsp1_valid}, 32'd0);
    chk("c_g0_res", rsp0_result, 32'd0);
    chk("c_g0_zero", {31'd0, rsp0_zero}, 32'd1);
    tick();
    chk("c_g1_rdy1", {31'd0, req1_ready}, 32'd1);
    chk("c_g1_rdy0", {31'd0, req0_ready}, 32'd0);
    tick(); tick();
    chk("c_g1_vld1", {31'd0, rsp1_valid}, 32'd1);
    chk("c_g1_res", rsp1_result, 32'hFFFF_FFFF);
    chk("c_g1_zero", {31'd0, rsp1_zero}, 32'd0);
    set0(1'b1, 32'd6, 32'd3, 4'b0000);
    tick();
    chk("c_g2_rdy0", {31'd0, req0_ready}, 32'd1);
    tick(); tick();
    chk("c_g2_vld0", {31'd0, rsp0_valid}, 32'd1);
    chk("c_g2_res", rsp0_result, 32'd2);

    // Backpressure on requester 1 (next in rotation); req0 keeps asking
    set1(1'b1, 32'h10, 32'h3, 4'b0110);
    rsp1_ready = 1'b0;
    tick();
    chk("bp_rdy1", {31'd0, req1_ready}, 32'd1);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld1", {31'd0, rsp1_valid}, 32'd1);
      chk("bp_res1", rsp1_result, 32'hD);
      chk("bp_rdy0", {31'd0, req0_ready}, 32'd0);
      chk("bp_rdy1_hold", {31'd0, req1_ready}, 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    set1(1'b0, 32'd0, 32'd0, 4'b0000);
    tick();
    chk("bp_rel_vld1", {31'd0, rsp1_valid}, 32'd0);

    // Wrap-around add on req0, then an unsupported op on req1
    set0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    #1;
    chk("wr_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    set0(1'b0, 32'd0, 32'd0, 4'b0000);
    set1(1'b1, 32'd5, 32'd6, 4'b1111);
    tick();
    chk("wr_vld0", {31'd0, rsp0_valid}, 32'd1);
    chk("wr_res", rsp0_result, 32'd0);
    chk("wr_zero", {31'd0, rsp0_zero}, 32'd1);
    tick();
    chk("il_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    set1(1'b0, 32'd0, 32'd0, 4'b0000);
    #1;
    chk("il_ctrl", {28'd0, alu_ctrl}, 32'hF);
    tick();
    chk("il_vld1", {31'd0, rsp1_valid}, 32'd1);
    chk("il_res", rsp1_result, 32'd0);
    chk("il_zero", {31'd0, rsp1_zero}, 32'd1);
    tick();

    // Reset while in EXEC
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set0(1'b1, 32'd1, 32'd2, 4'b0010);
    tick();
    set0(1'b0, 32'd0, 32'd0, 4'b0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("rx");
    tick();
    chk("rx_later_vld0", {31'd0, rsp0_valid}, 32'd0);

    // Reset while in RESP
    set0(1'b1, 32'd1, 32'd2, 4'b0010);
    tick();
    set0(1'b0, 32'd0, 32'd0, 4'b0000);
    tick();
    chk("rr_vld0_before", {31'd0, rsp0_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("rr");

    // Served normally after reset; operands changed during EXEC are ignored
    set0(1'b1, 32'd20, 32'd22, 4'b0010);
    #1;
    chk("oc_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    set0(1'b1, 32'd100, 32'd100, 4'b0110);
    tick();
    set0(1'b0, 32'd0, 32'd0, 4'b0000);
    chk("oc_vld0", {31'd0, rsp0_valid}, 32'd1);
    chk("oc_res", rsp0_result, 32'd42);
    chk("oc_zero", {31'd0, rsp0_zero}, 32'd0);
    chk("oc_alu_a", alu_a, 32'd20);
    chk("oc_ctrl", {28'd0, alu_ctrl}, 32'h2);
    rsp0_ready = 1'b1;
    tick();
    chk("oc_done_vld0", {31'd0, rsp0_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, for example the main datapath and a multi-cycle helper unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands are registered, presented to the ALU for one cycle, and the result and zero flag are captured and returned to the owning requester.
- Sits beside the ALU. Drives its alu_input1, alu_input2 and ALUControl inputs, and consumes alu_result and zero_flag.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU width.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand 1
- req0_b  input  WIDTH  requester 0 operand 2
- req0_op  input  4  requester 0 ALU control code
- rsp0_valid  output  1  result available for requester 0
- rsp0_ready  input  1  requester 0 consumes the result
- rsp0_result  output  WIDTH  result for requester 0
- rsp0_zero  output  1  zero flag for requester 0
- req1_*, rsp1_*  same as requester 0, for requester 1
- alu_a  output  WIDTH  to ALU alu_input1
- alu_b  output  WIDTH  to ALU alu_input2
- alu_ctrl  output  4  to ALU ALUControl
- alu_result  input  WIDTH  from ALU
- alu_zero  input  1  from ALU zero_flag

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - state=IDLE, last_grant=1 (so requester 0 wins the first contest), owner=0.
  - Operand, op, result and zero registers = 0.
  - All ready/valid outputs = 0.
  - alu_a=0, alu_b=0, alu_ctrl=4'b0000.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the requester with valid; if both are valid, the one != last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. This is combinational, at most one ready high.
  - On handshake: latch a, b and op; owner=N; last_grant=N; go to EXEC.
  - No valid: stay in IDLE, last_grant unchanged.
- EXEC (exactly 1 cycle):
  - ALU outputs come from the operand registers (they always do).
  - At the clock edge, latch alu_result and alu_zero into the result registers, then go to RESP.
- RESP:
  - rsp{owner}_valid=1; the other rsp valid is 0.
  - Result and zero are held stable until consumed.
  - On rsp{owner}_ready, go to IDLE. Otherwise hold indefinitely; no new requests are accepted.
- Latency: request accepted at edge T; rsp_valid high in the cycle after edge T+1 (2 cycles). Minimum issue interval is 3 cycles per operation.
- Op codes:
  - 0010 add, 0110 sub, 0000 and, 0001 or.
  - Any other code is forwarded unchanged; the ALU returns 0, so rsp_result=0 and rsp_zero=1. No error signalled.
- Arithmetic: wrap-around modulo 2^WIDTH is the ALU's behaviour; the arbiter performs no arithmetic.
- rspN_result/rspN_zero for the non-owner, or outside RESP: drive the registered values. Receivers must qualify with valid.
- A requester may drop valid before being granted; no request is latched without a handshake.
- Requester inputs are sampled only at the handshake edge; changes later are ignored.
- Reset during EXEC or RESP: the in-flight operation is discarded, no response is issued, and the block returns to the IDLE reset state.
- Starvation freedom: under continuous contention, grants strictly alternate 0,1,0,1.

Test Plan:
- After reset, req0 alone, a=5, b=7, op=0010: req0_ready in cycle 1, rsp0_valid two cycles later with result=12, zero=0; rsp1_valid stays 0.
- Both valid continuously, rsp ready tied high:
  - first request: req0 op 0110, a=9, b=9 → rsp0 result 0, zero=1.
  - next grant goes to req1 with a=0xF0F0_0000, b=0x0F0F_FFFF, op=0001 → rsp1 result 0xFFFF_FFFF.
  - grants continue alternating 0,1,0,1.
- Backpressure: rsp1_ready held low 5 cycles in RESP → rsp1_valid and result stable, both req ready 0 throughout; release → IDLE next cycle.
- Wrap/illegal: req0 a=0xFFFF_FFFF, b=1, op=0010 → result 0, zero=1; req1 op=4'b1111 → result 0, zero=1.
- Reset asserted in EXEC and again in RESP → no rsp_valid afterward, all outputs at reset values, next req0 request served normally.
- Operand change after handshake: req0 changes a/b/op the cycle after ready → response reflects the originally latched values.
